// File: rtl/ring_sample_scheduler.sv
// Byte-pair assembler feeding eight per-ring holding slots, round-robin arbitrated into one shared sample FIFO.
// Optional peak comparator on popped data is enabled by defining RING_SCHED_PEAK_EN.
module ring_sample_scheduler #(
  parameter int         DEPTH = 8,
  parameter logic [9:0] THRES = 10'd510
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte_data,
  output logic                     o_byte_ready,
  input  logic                     i_rd_en,
  output logic [5:0]               o_fifo_ch,
  output logic [9:0]               o_fifo_out,
  output logic                     o_out_valid,
  output logic                     o_peak,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_fifo_counter,
  output logic [7:0]               o_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {S_HI = 1'b0, S_LO = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_hi;
  logic [15:0]     r_slot [8];
  logic [7:0]      r_pending;
  logic [2:0]      r_rr_ptr;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;
  logic            r_out_valid;
  logic            r_peak;
  logic [5:0]      r_ch;
  logic [9:0]      r_out;

  logic            w_byte_ready;
  logic            w_hi_load;
  logic            w_slot_load;
  logic            w_grant;
  logic [2:0]      w_gidx;
  logic            w_rd;
  logic [7:0]      w_set;
  logic [7:0]      w_clr;
  logic [CW-1:0]   w_count_nxt;

  // The low byte is held off while its ring slot is still occupied, so a slot is never overwritten.
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b1;
    w_hi_load    = 1'b0;
    w_slot_load  = 1'b0;
    case (r_state)
      S_HI: begin
        w_byte_ready = 1'b1;
        if (i_byte_valid) begin
          w_hi_load   = 1'b1;
          w_state_nxt = S_LO;
        end else begin
          w_state_nxt = S_HI;
        end
      end
      S_LO: begin
        w_byte_ready = !r_pending[r_hi[7:5]];
        if (i_byte_valid && w_byte_ready) begin
          w_slot_load = 1'b1;
          w_state_nxt = S_HI;
        end else begin
          w_state_nxt = S_LO;
        end
      end
      default: begin
        w_state_nxt = S_HI;
      end
    endcase
  end

  // Descending scan: the last hit written is the nearest pending ring at or after r_rr_ptr.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = 3'd0;
    if (!r_full && (r_pending != 8'd0)) begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pending[r_rr_ptr + 3'(i)]) begin
          w_grant = 1'b1;
          w_gidx  = r_rr_ptr + 3'(i);
        end else begin
          w_grant = w_grant;
        end
      end
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_rd  = i_rd_en && !r_empty;
  assign w_set = w_slot_load ? (8'd1 << r_hi[7:5]) : 8'd0;
  assign w_clr = w_grant ? (8'd1 << w_gidx) : 8'd0;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_grant, w_rd})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_HI;
      r_hi      <= 8'd0;
      r_pending <= 8'd0;
      r_rr_ptr  <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_hi_load) r_hi <= i_byte_data;
      if (w_grant) r_rr_ptr <= w_gidx + 3'd1;
    end
  end

  // Data storage carries no reset; occupancy is tracked by r_pending and r_count.
  always_ff @(posedge i_clk) begin
    if (w_slot_load) r_slot[r_hi[7:5]] <= {r_hi, i_byte_data};
    if (w_grant) r_mem[r_wptr] <= r_slot[w_gidx];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_grant) r_wptr <= r_wptr + AW'(1'b1);
      if (w_rd) r_rptr <= r_rptr + AW'(1'b1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == CW'(1'b0));
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_peak      <= 1'b0;
      r_ch        <= 6'd0;
      r_out       <= 10'd0;
    end else begin
      r_out_valid <= w_rd;
      if (w_rd) begin
        r_ch  <= r_mem[r_rptr][15:10];
        r_out <= r_mem[r_rptr][9:0];
      end
`ifdef RING_SCHED_PEAK_EN
      r_peak <= w_rd && (r_mem[r_rptr][9:0] > THRES);
`else
      r_peak <= 1'b0;
`endif
    end
  end

`ifndef RING_SCHED_PEAK_EN
  logic w_unused_thres;
  assign w_unused_thres = ^THRES;
`endif

  assign o_byte_ready   = w_byte_ready;
  assign o_fifo_ch      = r_ch;
  assign o_fifo_out     = r_out;
  assign o_out_valid    = r_out_valid;
  assign o_peak         = r_peak;
  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_fifo_counter = r_count;
  assign o_pending      = r_pending;

endmodule

// File: tb/tb_ring_sample_scheduler.sv
// Randomized plus directed bench for ring_sample_scheduler, checked against a queue-based reference model
// and a scoreboard of expected popped words.
module tb_ring_sample_scheduler;
  localparam int         DEPTH = 8;
  localparam logic [9:0] THRES = 10'd510;

  logic       clk;
  logic       i_reset;
  logic       i_byte_valid;
  logic [7:0] i_byte_data;
  logic       o_byte_ready;
  logic       i_rd_en;
  logic [5:0] o_fifo_ch;
  logic [9:0] o_fifo_out;
  logic       o_out_valid;
  logic       o_peak;
  logic       o_empty;
  logic       o_full;
  logic [3:0] o_fifo_counter;
  logic [7:0] o_pending;

  ring_sample_scheduler #(.DEPTH(DEPTH), .THRES(THRES)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready), .i_rd_en(i_rd_en), .o_fifo_ch(o_fifo_ch), .o_fifo_out(o_fifo_out),
    .o_out_valid(o_out_valid), .o_peak(o_peak), .o_empty(o_empty), .o_full(o_full),
    .o_fifo_counter(o_fifo_counter), .o_pending(o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_phase;
  logic [7:0]  m_hi;
  logic [15:0] m_slot [8];
  logic [7:0]  m_pend;
  int          m_rr;
  logic [15:0] m_fifo [$];
  logic [5:0]  m_ch;
  logic [9:0]  m_out;
  bit          m_ov;
  bit          m_peak;
  logic [16:0] sb_q [$];
  logic [9:0]  obs_q [$];

  function automatic bit exp_peak(input logic [9:0] d);
`ifdef RING_SCHED_PEAK_EN
    return d > THRES;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rdy, acc, full, empty, rd, gnt;
    int g;
    logic [15:0] w;
    if (i_reset) begin
      m_phase = 1'b0; m_hi = 8'd0; m_pend = 8'd0; m_rr = 0;
      m_fifo.delete(); sb_q.delete();
      m_ch = 6'd0; m_out = 10'd0; m_ov = 1'b0; m_peak = 1'b0;
      chk_en = 1'b1;
    end else begin
      rdy   = m_phase ? !m_pend[m_hi[7:5]] : 1'b1;
      acc   = i_byte_valid && rdy;
      full  = (m_fifo.size() == DEPTH);
      empty = (m_fifo.size() == 0);
      rd    = i_rd_en && !empty;
      gnt = 1'b0; g = 0;
      if (!full) begin
        for (int i = 0; i < 8; i++) begin
          if (!gnt && m_pend[(m_rr + i) % 8]) begin gnt = 1'b1; g = (m_rr + i) % 8; end
        end
      end
      m_ov = rd; m_peak = 1'b0;
      if (rd) begin
        w = m_fifo.pop_front();
        m_ch = w[15:10]; m_out = w[9:0]; m_peak = exp_peak(w[9:0]);
        sb_q.push_back({m_peak, w});
      end
      if (gnt) begin
        m_fifo.push_back(m_slot[g]); m_pend[g] = 1'b0; m_rr = (g + 1) % 8;
      end
      if (acc) begin
        if (!m_phase) begin
          m_hi = i_byte_data; m_phase = 1'b1;
        end else begin
          m_slot[m_hi[7:5]] = {m_hi, i_byte_data}; m_pend[m_hi[7:5]] = 1'b1; m_phase = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle status comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_counter", 32'(o_fifo_counter), 32'(m_fifo.size()));
      check("empty", 32'(o_empty), 32'(m_fifo.size() == 0));
      check("full", 32'(o_full), 32'(m_fifo.size() == DEPTH));
      check("pending", 32'(o_pending), 32'(m_pend));
      check("byte_ready", 32'(o_byte_ready), 32'(m_phase ? !m_pend[m_hi[7:5]] : 1'b1));
      check("out_valid", 32'(o_out_valid), 32'(m_ov));
      check("fifo_ch_hold", 32'(o_fifo_ch), 32'(m_ch));
      check("fifo_out_hold", 32'(o_fifo_out), 32'(m_out));
      check("peak", 32'(o_peak), 32'(m_peak));
    end
  end

  // Scoreboard monitor: every presented word must match the next expected pop
  always @(negedge clk) begin
    logic [16:0] e;
    if (chk_en && o_out_valid) begin
      obs_q.push_back(o_fifo_out);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pop", 32'(o_out_valid), 32'(1'b0));
      end else begin
        e = sb_q.pop_front();
        check("sb_ch", 32'(o_fifo_ch), 32'(e[15:10]));
        check("sb_data", 32'(o_fifo_out), 32'(e[9:0]));
        check("sb_peak", 32'(o_peak), 32'(e[16]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    while (!o_byte_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!o_byte_ready) check("send_timeout", 32'(o_byte_ready), 32'(1'b1));
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic pop(input int n);
    i_rd_en = 1'b1;
    repeat (n) @(negedge clk);
    i_rd_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
  endtask

  initial begin
    i_reset = 1'b1; i_byte_valid = 1'b0; i_byte_data = 8'd0; i_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    // Single word: ch 4, data 564
    send_word(8'h12, 8'h34);
    @(negedge clk);
    check("single_cnt", 32'(o_fifo_counter), 32'd1);
    pop(1);
    check("single_ch", 32'(o_fifo_ch), 32'd4);
    check("single_data", 32'(o_fifo_out), 32'd564);
    check("single_valid", 32'(o_out_valid), 32'd1);

    // Read of an empty FIFO is ignored
    pop(1);
    check("empty_rd_valid", 32'(o_out_valid), 32'd0);
    check("empty_rd_cnt", 32'(o_fifo_counter), 32'd0);

    // Round robin after filling with ring 0
    for (int k = 0; k < 8; k++) send_word(8'h00, 8'(8'h10 + k));
    repeat (2) @(negedge clk);
    check("rr_full", 32'(o_full), 32'd1);
    send_word(8'hC0, 8'h01);
    send_word(8'h40, 8'h02);
    check("rr_pending", 32'(o_pending), 32'h44);
    obs_q.delete();
    pop(14);
    check("rr_pops", 32'(obs_q.size()), 32'd10);
    if (obs_q.size() >= 2) begin
      check("rr_second_last", 32'(obs_q[obs_q.size()-2]), 32'd2);
      check("rr_last", 32'(obs_q[obs_q.size()-1]), 32'd1);
    end

    // Backpressure on a blocked ring-3 slot
    for (int k = 0; k < 8; k++) send_word(8'h20, 8'(k));
    send_word(8'h60, 8'h00);
    send_byte(8'h60);
    i_byte_valid = 1'b1; i_byte_data = 8'h33;
    repeat (4) @(negedge clk);
    check("bp_stall", 32'(o_byte_ready), 32'd0);
    i_rd_en = 1'b1;
    send_byte(8'h33);
    pop(14);

    // Simultaneous read and write at count 4
    for (int k = 0; k < 4; k++) send_word(8'hA0, 8'(k));
    @(negedge clk);
    check("rw_pre_cnt", 32'(o_fifo_counter), 32'd4);
    send_word(8'hA4, 8'h55);
    pop(1);
    check("rw_same_cnt", 32'(o_fifo_counter), 32'd4);
    pop(8);

    // Peak threshold: 510 then 511
    send_word(8'h01, 8'hFE);
    send_word(8'h01, 8'hFF);
    @(negedge clk);
    pop(1);
    check("peak_510", 32'(o_peak), 32'd0);
    pop(1);
    check("peak_511", 32'(o_peak), 32'(exp_peak(10'd511)));

    // Reset in the middle of a word
    send_byte(8'hFF);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    send_word(8'h00, 8'h05);
    repeat (2) @(negedge clk);
    check("rst_cnt", 32'(o_fifo_counter), 32'd1);
    check("rst_pending", 32'(o_pending), 32'd0);
    pop(1);
    check("rst_ch", 32'(o_fifo_ch), 32'd0);
    check("rst_data", 32'(o_fifo_out), 32'd5);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_byte_valid = ($urandom_range(0, 3) != 0);
      i_byte_data  = 8'($urandom);
      i_rd_en      = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_reset      = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    i_byte_valid = 1'b0; i_rd_en = 1'b0; i_reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ring_sample_scheduler.md
# ring_sample_scheduler

Sits between the serial byte source and the shared sample FIFO in the acquisition front end. It assembles byte pairs into 16-bit {channel, data} words and parks each word in a one-entry holding slot for its ring (ring = channel[5:3]). It shares the single sample FIFO among the eight ring slots with round-robin arbitration. It also flags peaks on data read out of the FIFO.

## Interface
Parameters:
- DEPTH, 8, shared FIFO depth in words; power of two, at least 2.
- THRES, 510, 10-bit peak threshold; the peak comparison is strictly greater-than.

Ports:
- clk  in  1  single clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  byte stream; the first byte of each pair is the high byte.
- byte_ready  out  1  a byte transfers on a cycle where byte_valid and byte_ready are both high.
- rd_en  in  1  pop request for the shared FIFO.
- fifo_ch  out  6  channel of the popped word.
- fifo_out  out  10  data of the popped word.
- out_valid  out  1  one-cycle pulse; fifo_ch and fifo_out were updated on this edge.
- peak  out  1  pulses with out_valid when fifo_out > THRES.
- empty  out  1  shared FIFO holds no words.
- full  out  1  shared FIFO holds DEPTH words.
- fifo_counter  out  $clog2(DEPTH)+1  number of words in the shared FIFO.
- pending  out  8  per-ring holding-slot occupancy.

## Operation
- **Word format.** word = {hi, lo}.
  - channel = word[15:10] = hi[7:2].
  - data = word[9:0] = {hi[1:0], lo}.
  - ring = hi[7:5].
- **Assembler FSM states.**
  - S_HI: byte_ready=1. An accepted byte is stored in hi_reg; next state is S_LO.
  - S_LO: byte_ready = !pending[hi_reg[7:5]]. An accepted byte writes {channel, data} into slot[ring] and sets pending[ring]; next state is S_HI.
- **Slot interlock.** byte_ready is computed from the registered pending vector. A slot that is granted this cycle still blocks byte_ready this cycle, which costs one bubble cycle. As a result, a slot is never overwritten.
- **Arbiter.**
  - It runs each cycle in which !full and pending is nonzero.
  - It grants the first pending ring at or after rr_ptr, counting modulo 8.
  - On a grant, the 16-bit slot word is written into the FIFO, pending[g] is cleared, and rr_ptr becomes (g+1) mod 8.
  - At most one write per cycle.
  - When nothing is granted, rr_ptr holds.
- **FIFO.**
  - Circular buffer of 16-bit words with wrapping read and write pointers.
  - A write is suppressed when full, using the registered flag.
  - A read is accepted when rd_en=1 and !empty (registered flag). Reads with rd_en=1 while empty are ignored: no out_valid, no state change.
  - fifo_counter: +1 for a write only, -1 for a read only, unchanged for a simultaneous read and write.
  - When full, a read in the same cycle does not enable a write; the write waits until the next cycle.
  - fifo_ch and fifo_out hold their last values between pops.
- **Reset** (sync, any time, including mid-word). All of the following return to their reset values:
  - FSM goes to S_HI and a half-assembled hi byte is discarded.
  - pending = 0, rr_ptr = 0.
  - FIFO pointers and fifo_counter = 0.
  - empty=1, full=0, out_valid=0, peak=0, fifo_ch=0, fifo_out=0.
  - byte_ready=1 after the reset edge.

## Timing
- **Ingest to FIFO.** The low byte is accepted at edge N, so pending[r] is set after N. The earliest grant is at edge N+1; after N+1, fifo_counter has incremented and empty=0.
- **Read latency.** rd_en is accepted at edge M. fifo_ch, fifo_out, out_valid and peak are valid after edge M, for one cycle.
- **Throughput.** One word in per two byte cycles. Pops run at one word per cycle.
- empty, full and fifo_counter are registered and update on the same edge as the pointers.

## Configuration
- Macro: RING_SCHED_PEAK_EN.
  - Defined: the comparator is present and peak = out_valid && (fifo_out > THRES).
  - Undefined: no comparator; peak is tied to 0 and THRES is unused.

## Test plan
- **Single word.** Reset, then bytes 0x12, 0x34 → pending[0]=1 for one cycle, then fifo_counter=1. rd_en → fifo_ch=4, fifo_out=564, out_valid=1, peak=1.
- **Round robin.**
  - Fill the FIFO with 8 ring-0 words and no reads → full=1, fifo_counter=8, rr_ptr=1.
  - Load ring 6 (0xC0, 0x01), then ring 2 (0x40, 0x02).
  - Pop one word per cycle → the FIFO receives the ring-2 word first, then the ring-6 word.
  - The last two pops return data 2 then 1.
- **Backpressure.** With pending[3]=1 and the FIFO full, send 0x60 → accepted. The next byte_ready stays 0 until the FIFO drains and slot 3 is granted; it rises one cycle after pending[3] clears.
- **Boundaries.**
  - rd_en on an empty FIFO → no out_valid, fifo_counter stays 0.
  - 8 writes → full=1; a 9th word remains pending.
  - Read and write in the same cycle at count 4 → count stays 4.
- **Peak threshold.** Words (0x01, 0xFE) and (0x01, 0xFF) → data 510 gives peak=0; data 511 gives peak=1. With RING_SCHED_PEAK_EN undefined, peak=0 for both.
- **Reset mid-word.** Send 0xFF, assert reset for one cycle, then send 0x00, 0x05 → exactly one word in the FIFO with ch=0 and data=5; pending and rr_ptr are cleared.
